// File: rtl/delay_line_buffer.sv
// Multi-channel circular delay buffer: per-channel write pointers, 1-cycle delayed read tap.
// Optional fill gating (zero for reads past written history) is enabled by DELAY_BUFFER_FILL_GATE_EN.
module delay_line_buffer #(
    parameter int unsigned BUFFER_SIZE  = 1024,
    parameter int unsigned DATA_SIZE    = 24,
    parameter int unsigned NUM_CHANNELS = 2,
    localparam int unsigned AW = $clog2(BUFFER_SIZE),
    localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic [CW-1:0]               in_ch,
    input  logic signed [DATA_SIZE-1:0] in_data,
    input  logic [AW-1:0]               rd_delay,
    output logic                        out_valid,
    output logic [CW-1:0]               out_ch,
    output logic signed [DATA_SIZE-1:0] out_data,
    output logic [AW:0]                 fill
);

    localparam logic [CW:0]   NCH   = (CW+1)'(NUM_CHANNELS);
    localparam int unsigned   DEPTH = NUM_CHANNELS * BUFFER_SIZE;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_BYPASS,
        SEL_RAM
    } sel_e;

    logic                        ch_ok;
    logic                        accept;
    logic                        empty_gate;
    logic [AW-1:0]               cur_wptr;
    logic [AW-1:0]               rdptr;
    logic [AW-1:0]               wptr_q [NUM_CHANNELS];
    logic [AW-1:0]               wptr_d [NUM_CHANNELS];
    logic signed [DATA_SIZE-1:0] mem [DEPTH];
    logic signed [DATA_SIZE-1:0] ram_q;
    logic signed [DATA_SIZE-1:0] byp_q;
    logic                        out_valid_q;
    logic [CW-1:0]               out_ch_q;
    sel_e                        sel_q;
    sel_e                        sel_d;

    assign ch_ok    = ({1'b0, in_ch} < NCH);
    assign accept   = in_valid && ch_ok && !clear;
    assign cur_wptr = ch_ok ? wptr_q[in_ch] : '0;
    assign rdptr    = cur_wptr - rd_delay;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            wptr_d[i] = wptr_q[i];
            if (clear) begin
                wptr_d[i] = '0;
            end else if (accept && (in_ch == CW'(i))) begin
                wptr_d[i] = wptr_q[i] + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                wptr_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                wptr_q[i] <= wptr_d[i];
            end
        end
    end

`ifdef DELAY_BUFFER_FILL_GATE_EN
    localparam logic [AW:0] FULL = (AW+1)'(BUFFER_SIZE);

    logic [AW:0] fcnt_q [NUM_CHANNELS];
    logic [AW:0] fcnt_d [NUM_CHANNELS];
    logic [AW:0] cur_fcnt;
    logic [AW:0] fill_q;

    assign cur_fcnt   = ch_ok ? fcnt_q[in_ch] : '0;
    assign empty_gate = ({1'b0, rd_delay} >= cur_fcnt);
    assign fill       = fill_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            fcnt_d[i] = fcnt_q[i];
            if (clear) begin
                fcnt_d[i] = '0;
            end else if (accept && (in_ch == CW'(i)) && (fcnt_q[i] != FULL)) begin
                fcnt_d[i] = fcnt_q[i] + (AW+1)'(1);
            end
        end
    end

    // A flush also zeroes the reported fill so the cycle after clear already reads empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                fcnt_q[i] <= '0;
            end
            fill_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                fcnt_q[i] <= fcnt_d[i];
            end
            fill_q <= clear ? '0 : cur_fcnt;
        end
    end
`else
    assign empty_gate = 1'b0;
    assign fill       = '0;
`endif

    always_comb begin
        sel_d = SEL_RAM;
        if (rd_delay == '0) begin
            sel_d = SEL_BYPASS;
        end else if (empty_gate) begin
            sel_d = SEL_ZERO;
        end
    end

    // Unreset RAM with registered read port; ram_q is only selected after an accepted read.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{in_ch, cur_wptr}] <= in_data;
            ram_q                  <= mem[{in_ch, rdptr}];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            byp_q       <= '0;
            sel_q       <= SEL_ZERO;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                out_ch_q <= in_ch;
                byp_q    <= in_data;
                sel_q    <= sel_d;
            end
        end
    end

    always_comb begin
        out_data = '0;
        case (sel_q)
            SEL_BYPASS: out_data = byp_q;
            SEL_RAM:    out_data = ram_q;
            default:    out_data = '0;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_delay_line_buffer.sv
// Scoreboard bench for delay_line_buffer: driver pushes expected outputs from a history-based
// model, a negedge monitor pops and compares whenever out_valid is seen.
module tb_delay_line_buffer;

    localparam int BS = 1024;
    localparam int DW = 24;
    localparam int NC = 3;
    localparam int CW = 2;
    localparam int AW = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 clear = 1'b0;
    logic                 in_valid = 1'b0;
    logic [CW-1:0]        in_ch = '0;
    logic signed [DW-1:0] in_data = '0;
    logic [AW-1:0]        rd_delay = '0;
    logic                 out_valid;
    logic [CW-1:0]        out_ch;
    logic signed [DW-1:0] out_data;
    logic [AW:0]          fill;

    delay_line_buffer #(
        .BUFFER_SIZE (BS),
        .DATA_SIZE   (DW),
        .NUM_CHANNELS(NC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ch    (in_ch),
        .in_data  (in_data),
        .rd_delay (rd_delay),
        .out_valid(out_valid),
        .out_ch   (out_ch),
        .out_data (out_data),
        .fill     (fill)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [CW-1:0]        ch;
        logic signed [DW-1:0] d;
        bit                   care;
    } out_t;

    typedef struct {
        int          c;
        logic [AW:0] f;
        bit          care;
    } fill_t;

    out_t  oq[$];
    fill_t fq[$];
    int    checks = 0;
    int    passed = 0;

    logic [CW-1:0]        last_ch = '0;
    logic signed [DW-1:0] last_d = '0;
    bit                   last_care = 1'b1;

    // Reference model: per-channel sample history since reset/clear, plus a sparse picture
    // of the (never reset) storage for the ungated build.
    int                   wcount [NC];
    logic signed [DW-1:0] hist [NC][$];
    logic signed [DW-1:0] mm [NC*BS];
    bit                   known [NC*BS];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            wcount[c] = 0;
            hist[c].delete();
        end
    endtask

    task automatic flush_all();
        oq.delete();
        fq.delete();
        model_reset();
        last_ch   = '0;
        last_d    = '0;
        last_care = 1'b1;
    endtask

    task automatic drive(bit v, int ch, logic signed [DW-1:0] data, int d, bit clr);
        out_t  o;
        fill_t f;
        int    fc;
        int    base;
        int    a;
        @(posedge clk);
        #1;
        in_valid = v;
        in_ch    = CW'(ch);
        in_data  = data;
        rd_delay = AW'(d);
        clear    = clr;
        fc = 0;
        if (ch < NC) fc = (wcount[ch] < BS) ? wcount[ch] : BS;
        f.c = cyc;
`ifdef DELAY_BUFFER_FILL_GATE_EN
        f.care = (ch < NC);
        f.f    = clr ? '0 : (AW+1)'(fc);
`else
        f.care = 1'b1;
        f.f    = '0;
`endif
        fq.push_back(f);
        if (clr) begin
            model_reset();
        end else if (v && ch < NC) begin
            base   = ch * BS;
            o.ch   = CW'(ch);
            o.care = 1'b1;
            o.d    = data;
            if (d != 0) begin
`ifdef DELAY_BUFFER_FILL_GATE_EN
                if (d >= fc) o.d = '0;
                else o.d = hist[ch][hist[ch].size() - d];
`else
                a      = base + ((wcount[ch] % BS) + BS - d) % BS;
                o.care = known[a];
                o.d    = mm[a];
`endif
            end
            oq.push_back(o);
            mm[base + wcount[ch] % BS]    = data;
            known[base + wcount[ch] % BS] = 1'b1;
            hist[ch].push_back(data);
            if (hist[ch].size() > BS) void'(hist[ch].pop_front());
            wcount[ch]++;
        end
    endtask

    always @(negedge clk) begin : monitor
        out_t  o;
        fill_t f;
        if (rst_n) begin
            while (fq.size() > 0 && fq[0].c < cyc) begin
                f = fq.pop_front();
                if (f.care) chk("fill", 32'(fill), 32'(f.f));
            end
            if (out_valid === 1'b1) begin
                if (oq.size() == 0) begin
                    chk("unexpected_out_valid", 32'(1), 32'(0));
                end else begin
                    o = oq.pop_front();
                    chk("out_ch", 32'(out_ch), 32'(o.ch));
                    if (o.care) chk("out_data", 32'(out_data), 32'(o.d));
                    last_ch   = o.ch;
                    last_d    = o.d;
                    last_care = o.care;
                end
            end else begin
                chk("out_valid_low", 32'(out_valid), 32'(0));
                chk("hold_ch", 32'(out_ch), 32'(last_ch));
                if (last_care) chk("hold_data", 32'(out_data), 32'(last_d));
            end
        end
    end

    task automatic check_zero_outputs(string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_ch"},    32'(out_ch),    32'(0));
        chk({tag, "_data"},  32'(out_data),  32'(0));
        chk({tag, "_fill"},  32'(fill),      32'(0));
    endtask

    initial begin
        int r;
        int d;
        flush_all();
        #1 rst_n = 1'b0;
        #2 check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Ramp on ch0 with a 3-sample delay, then idle so fill=10 is observed.
        for (int k = 1; k <= 10; k++) drive(1, 0, DW'(k), 3, 0);
        drive(0, 0, '0, 0, 0);
        drive(0, 0, '0, 0, 0);

        // Interleaved channels after a flush.
        drive(0, 0, '0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, DW'(100 + k), 1, 0);
            drive(1, 1, DW'(-(100 + k)), 1, 0);
        end

        // Out-of-range channel must not disturb ch0.
        drive(1, 3, DW'(555), 1, 0);
        drive(1, 0, DW'(777), 1, 0);
        drive(0, 0, '0, 0, 0);

        // Clear with a simultaneous sample after 20 writes.
        drive(0, 1, '0, 0, 1);
        for (int k = 0; k < 20; k++) drive(1, 1, DW'($urandom), $urandom_range(0, 25), 0);
        drive(1, 1, DW'(999), 0, 1);
        drive(1, 1, DW'(42), 5, 0);
        drive(0, 1, '0, 0, 0);

        // Long run through pointer wrap and fill saturation.
        drive(0, 0, '0, 0, 1);
        for (int i = 0; i < 1030; i++) drive(1, 0, DW'(i), BS - 1, 0);
        drive(0, 0, '0, 0, 0);

        // Randomized traffic including invalid channels and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 3);
            d = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, 8) : $urandom_range(0, BS - 1);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), DW'($urandom), d,
                  $urandom_range(0, 49) == 0);
        end

        // Asynchronous reset with a sample in flight.
        drive(1, 0, DW'(123), 0, 0);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        #1 check_zero_outputs("async_reset");
        flush_all();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Bypass path straight out of reset.
        for (int k = 0; k < 5; k++) drive(1, k % 2, 24'sh7FFFFF, 0, 0);
        for (int k = 0; k < 4; k++) drive(1, 0, DW'(k + 1), 2, 0);
        repeat (3) drive(0, 0, '0, 0, 0);

        for (int i = 0; i < 20 && oq.size() > 0; i++) @(posedge clk);
        chk("drain_empty", 32'(oq.size()), 32'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/delay_line_buffer.md
# delay_line_buffer

Multi-channel circular delay buffer for the pitch-shifter datapath. Each sample written to a channel is stored at that channel's auto-incrementing write pointer. In the same cycle, the sample delayed by a programmable number of samples is read back from that channel. It sits between the audio codec sample interface and the pitch-shift read-tap logic, and replaces hand-managed write/read addressing with per-channel pointers, fill tracking and a valid handshake.

## Interface
Parameters:
- BUFFER_SIZE, 1024, samples per channel; must be a power of two, ≥ 4
- DATA_SIZE, 24, signed sample width in bits
- NUM_CHANNELS, 2, independent channels; ≥ 1

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, asynchronous and active-low
- clear  in  1  synchronous flush of all pointers and fill counts
- in_valid  in  1  sample present on in_data this cycle
- in_ch  in  max(1,$clog2(NUM_CHANNELS))  channel of the input sample
- in_data  in  DATA_SIZE  signed input sample
- rd_delay  in  $clog2(BUFFER_SIZE)  read delay in samples; 0 = the sample written this cycle
- out_valid  out  1  out_data valid this cycle
- out_ch  out  max(1,$clog2(NUM_CHANNELS))  channel of out_data
- out_data  out  DATA_SIZE  signed delayed sample
- fill  out  $clog2(BUFFER_SIZE)+1  fill count of the channel addressed by in_ch, registered

## Operation
- Storage is a single RAM of NUM_CHANNELS×BUFFER_SIZE words, addressed {ch, ptr}. The RAM is not reset.
- Each channel has a write pointer wptr[ch] (width $clog2(BUFFER_SIZE)) and a fill count fcnt[ch] that saturates at BUFFER_SIZE.
- Accepted sample: in_valid=1, in_ch<NUM_CHANNELS and clear=0. On an accepted sample:
  - write in_data to {in_ch, wptr[in_ch]};
  - set rdptr = (wptr[in_ch] − rd_delay) mod BUFFER_SIZE, with natural wrap and no special case at 0;
  - increment wptr[in_ch] with wrap from BUFFER_SIZE−1 to 0;
  - increment fcnt[in_ch] if it is below BUFFER_SIZE.
- rd_delay=0 bypasses the RAM and returns in_data. No read-during-write hazard exists because the write address equals the read address only when rd_delay=0.
- Fill gating: if rd_delay ≥ fcnt[in_ch] before the increment, out_data is forced to 0.
  - Exception: rd_delay=0 always returns in_data.
- in_valid with in_ch ≥ NUM_CHANNELS: no write, no pointer change, out_valid=0 next cycle.
- clear=1: all wptr and fcnt are set to 0 next cycle. A simultaneous in_valid is dropped and out_valid=0 next cycle. Clear takes priority.
- Channels are fully independent. Any interleaving of in_ch, including the same channel on consecutive cycles, is legal.
- No backpressure. One sample per cycle is the maximum rate.

## Timing
- Latency is 1 cycle. out_valid, out_ch and out_data register on the clk edge after acceptance.
- out_valid is a one-cycle pulse per accepted sample. out_ch and out_data hold their last value while out_valid=0.
- fill reflects fcnt[in_ch] as it was before the current cycle's update, registered 1 cycle.
- rd_delay is sampled only in the accepting cycle.
- Reset (asynchronous assert, synchronous deassert by the system):
  - out_valid=0, out_ch=0, out_data=0, fill=0, all wptr=0, all fcnt=0.
  - Reset asserted mid-stream discards the in-flight output. After release, all channels read as empty.

## Configuration
- DELAY_BUFFER_FILL_GATE_EN
  - Defined: fill gating as described under Operation. Reads beyond the samples written since reset or clear return 0.
  - Undefined: fcnt logic is removed, fill ties to 0, and out_data always returns RAM content, which is stale or undefined before the first wrap.
    - Exception: rd_delay=0 still returns in_data.

## Test plan
- Reset, then on ch0 write 1,2,…,10 with rd_delay=3 -> outputs 0,0,0,1,2,…,7, each one cycle after its input; fill for ch0 ends at 10 (FILL_GATE_EN).
- Interleave ch0 = 100+k and ch1 = −(100+k) on alternating cycles, rd_delay=1 -> each channel returns only its own previous sample; the first output per channel is 0.
- Write 1030 samples to ch0 with value = index and rd_delay=1023 -> sample 1023 returns 0, sample 1029 returns 6; fill saturates at 1024; wptr wraps without glitch.
- rd_delay=0 with in_data=0x7FFFFF on every cycle from reset -> out_data=0x7FFFFF on the next cycle, including the very first sample.
- clear together with in_valid after 20 writes -> no out_valid the next cycle; a following write with rd_delay=5 returns 0, and fill=0 is observed in the cycle after clear.
- in_ch=NUM_CHANNELS with in_valid=1 -> no out_valid; ch0 pointer and fill unchanged. Assert rst_n low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
